id_ex_operand_stage: RTL
========================

ID_EX_OPERAND_STAGE -- requirements
Module: id_ex_operand_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-002 SHALL have parameters DATA_W default 16 (operand width) and REG_AW default 3 (register address width, 8 registers, r0 reads as zero).
REQ-003 SHALL have ID-side inputs: id_valid 1 (instruction present); id_ctrl 5 (ALU code); id_rs_addr/id_rt_addr REG_AW; id_rs_data/id_rt_data DATA_W (register file read); id_imm DATA_W; id_use_imm 1 (B = imm); id_rd_addr REG_AW; id_reg_write 1; id_mem_read 1; id_mem_write 1.
REQ-004 SHALL have control inputs: flush 1 (kill the ID instruction); hold 1 (downstream freeze).
REQ-005 SHALL have forwarding inputs: mem_rd_addr REG_AW, mem_reg_write 1, mem_result DATA_W (MEM stage); wb_rd_addr REG_AW, wb_reg_write 1, wb_result DATA_W (WB stage).
REQ-006 SHALL have outputs: ex_valid 1; ex_ctrl 5; ex_op_a DATA_W; ex_op_b DATA_W (both feed the ALU); ex_store_data DATA_W; ex_rd_addr REG_AW; ex_reg_write 1; ex_mem_read 1; ex_mem_write 1; stall_req 1 (freeze PC/IF/ID).

Function
REQ-007 SHALL hold one instruction in a register set (valid, ctrl, rs/rt addr, rs/rt data, imm, use_imm, rd, reg_write, mem_read, mem_write), updated only on the rising edge of clk.
REQ-008 SHALL assert stall_req combinationally when id_valid & ex_valid & ex_mem_read & ex_rd_addr!=0 & (ex_rd_addr==id_rs_addr | (ex_rd_addr==id_rt_addr & !id_use_imm) | (ex_rd_addr==id_rt_addr & id_mem_write)) (load-use).
REQ-009 SHALL apply per-edge priority rst > hold > flush > stall_req > capture.
REQ-010 SHALL, on hold, keep all fields except rs/rt data; those SHALL be overwritten with their current forwarded values (REQ-013), so forwarding sources lost during a freeze are not lost; stall_req SHALL still be evaluated.
REQ-011 SHALL, on flush or stall_req (no hold), load a bubble: valid=0, reg_write=0, mem_read=0, mem_write=0, ctrl=0; other fields don't-care.
REQ-012 SHALL, on capture, load ID fields with valid=id_valid; rs/rt data SHALL be taken from wb_result when wb_reg_write & wb_rd_addr==addr & addr!=0 (register-file write-through), else id data; data for addr 0 SHALL be 0.
REQ-013 SHALL forward combinationally in EX: per operand, source = mem_result if mem_reg_write & mem_rd_addr==addr & addr!=0; else wb_result if wb_reg_write & wb_rd_addr==addr & addr!=0; else registered data (MEM beats WB).
REQ-014 SHALL drive ex_op_a = forwarded rs; ex_op_b = registered imm if use_imm else forwarded rt; ex_store_data = forwarded rt always.
REQ-015 SHALL gate outputs: when ex_valid=0, ex_reg_write, ex_mem_read, ex_mem_write SHALL be 0 and forwarding SHALL still be computed (no X propagation).
REQ-016 SHALL pass ctrl through unmodified; codes 0-16 are legal, 17-31 are passed unchanged (ALU defines behaviour).
REQ-017 SHALL have zero added latency: ID-to-EX is exactly one cycle, plus one bubble cycle per load-use stall.

Reset
REQ-018 SHALL, on rst at the clock edge, clear all registers to 0: ex_valid=0, ex_ctrl=0, ex_op_a/b=0 (absent forwarding), ex_rd_addr=0, all write/read enables 0.
REQ-019 SHALL make stall_req 0 during and after reset until a valid load reaches EX; reset mid-stall SHALL drop the bubble and stall immediately.

Structure
REQ-020 SHALL take DATA_W, REG_AW, CTRL_W=5 and the ALU code constants (PASS_A=0 ... SLT_SIGNED=16) from the shared cpu package, which is also used by the ALU.
REQ-021 SHALL instantiate one sub-module, operand_forward_mux, twice (rs, rt), implementing REQ-013.

Verification
REQ-022 add r1 then add r2,r1,r3 back-to-back; mem_result=0x0005 for r1 -> ex_op_a=0x0005 in the second instruction's EX cycle.
REQ-023 lw r4 followed by add r5,r4,r4 -> stall_req=1 for exactly one cycle, one bubble (ex_valid=0), then add in EX with ex_op_a=ex_op_b=wb_result (0x1234).
REQ-024 mem and wb both write r2 (mem_result=0xAAAA, wb_result=0x5555) -> ex_op_a=0xAAAA; rs=r0 with mem writing r0 -> ex_op_a=0x0000.
REQ-025 hold for 3 cycles while wb_result=0x00FF for r6 is presented only in cycle 1 -> after release ex_op_a=0x00FF; hold+flush same cycle -> contents kept.
REQ-026 flush with id_valid=1 id_mem_write=1 -> next cycle ex_valid=0, ex_mem_write=0; rst asserted during stall -> next cycle all outputs 0, stall_req=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and ALU operation codes.
// The ALU and the ID/EX operand stage both use these.
package cpu_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_REG_AW = 3;
  localparam int CTRL_W     = 5;

  // Codes 17-31 are not listed here; they travel through the pipeline unchanged.
  typedef enum logic [CTRL_W-1:0] {
    PASS_A     = 5'd0,
    ADD        = 5'd1,
    SUB        = 5'd2,
    AND_OP     = 5'd3,
    OR_OP      = 5'd4,
    XOR_OP     = 5'd5,
    NOR_OP     = 5'd6,
    SLL        = 5'd7,
    SRL        = 5'd8,
    SRA        = 5'd9,
    LUI        = 5'd10,
    PASS_B     = 5'd11,
    MUL        = 5'd12,
    SEQ        = 5'd13,
    SNE        = 5'd14,
    SLT        = 5'd15,
    SLT_SIGNED = 5'd16
  } alu_op_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ID/EX boundary bundle: ID-side instruction fields, pipeline control,
// MEM/WB forwarding sources and the registered EX-side view.
interface id_ex_operand_stage_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW
);
  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_use_imm;
  logic [REG_AW-1:0] id_rd_addr;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;

  logic              flush;
  logic              hold;

  logic [REG_AW-1:0] mem_rd_addr;
  logic              mem_reg_write;
  logic [DATA_W-1:0] mem_result;
  logic [REG_AW-1:0] wb_rd_addr;
  logic              wb_reg_write;
  logic [DATA_W-1:0] wb_result;

  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_op_a;
  logic [DATA_W-1:0] ex_op_b;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              stall_req;

  modport master (
    output id_valid, id_ctrl, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_rd_addr, id_reg_write, id_mem_read, id_mem_write,
           flush, hold,
           mem_rd_addr, mem_reg_write, mem_result, wb_rd_addr, wb_reg_write, wb_result,
    input  ex_valid, ex_ctrl, ex_op_a, ex_op_b, ex_store_data, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, stall_req
  );

  modport slave (
    input  id_valid, id_ctrl, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_rd_addr, id_reg_write, id_mem_read, id_mem_write,
           flush, hold,
           mem_rd_addr, mem_reg_write, mem_result, wb_rd_addr, wb_reg_write, wb_result,
    output ex_valid, ex_ctrl, ex_op_a, ex_op_b, ex_store_data, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, stall_req
  );

endinterface

// File: rtl/operand_forward_mux.sv
// Selects the newest value of one source register: MEM result, then WB
// result, then the value captured at ID. r0 never matches a producer.
module operand_forward_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] fwd_data
);

  always_comb begin
    fwd_data = reg_data;
    if (addr != '0) begin
      if (mem_reg_write && (mem_rd_addr == addr)) begin
        fwd_data = mem_result;
      end else if (wb_reg_write && (wb_rd_addr == addr)) begin
        fwd_data = wb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use stall detection and EX-side operand
// forwarding. Edge priority: rst > hold > flush/stall bubble > capture.
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  id_ex_operand_stage_if.slave bus
);

  logic              valid_q,     valid_d;
  logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
  logic [REG_AW-1:0] rs_addr_q,   rs_addr_d;
  logic [REG_AW-1:0] rt_addr_q,   rt_addr_d;
  logic [DATA_W-1:0] rs_data_q,   rs_data_d;
  logic [DATA_W-1:0] rt_data_q,   rt_data_d;
  logic [DATA_W-1:0] imm_q,       imm_d;
  logic              use_imm_q,   use_imm_d;
  logic [REG_AW-1:0] rd_q,        rd_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;

  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  logic [DATA_W-1:0] wt_rs, wt_rt;
  logic              stall_req;

  operand_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .addr(rs_addr_q), .reg_data(rs_data_q),
    .mem_reg_write(bus.mem_reg_write), .mem_rd_addr(bus.mem_rd_addr), .mem_result(bus.mem_result),
    .wb_reg_write(bus.wb_reg_write), .wb_rd_addr(bus.wb_rd_addr), .wb_result(bus.wb_result),
    .fwd_data(fwd_rs)
  );

  operand_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .addr(rt_addr_q), .reg_data(rt_data_q),
    .mem_reg_write(bus.mem_reg_write), .mem_rd_addr(bus.mem_rd_addr), .mem_result(bus.mem_result),
    .wb_reg_write(bus.wb_reg_write), .wb_rd_addr(bus.wb_rd_addr), .wb_result(bus.wb_result),
    .fwd_data(fwd_rt)
  );

  // Register file is read and written in the same cycle, so WB wins at capture.
  always_comb begin
    wt_rs = bus.id_rs_data;
    wt_rt = bus.id_rt_data;
    if (bus.id_rs_addr == '0) begin
      wt_rs = '0;
    end else if (bus.wb_reg_write && (bus.wb_rd_addr == bus.id_rs_addr)) begin
      wt_rs = bus.wb_result;
    end
    if (bus.id_rt_addr == '0) begin
      wt_rt = '0;
    end else if (bus.wb_reg_write && (bus.wb_rd_addr == bus.id_rt_addr)) begin
      wt_rt = bus.wb_result;
    end
  end

  // rt only matters to a load-use hazard when it is a real ALU operand or store data.
  assign stall_req = !rst && bus.id_valid && valid_q && mem_read_q && (rd_q != '0) &&
                     ((rd_q == bus.id_rs_addr) ||
                      ((rd_q == bus.id_rt_addr) && (!bus.id_use_imm || bus.id_mem_write)));

  always_comb begin
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (bus.hold) begin
      // Refresh operand data so producers that retire during the freeze are kept.
      rs_data_d = fwd_rs;
      rt_data_d = fwd_rt;
    end else if (bus.flush || stall_req) begin
      valid_d     = 1'b0;
      ctrl_d      = '0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else begin
      valid_d     = bus.id_valid;
      ctrl_d      = bus.id_ctrl;
      rs_addr_d   = bus.id_rs_addr;
      rt_addr_d   = bus.id_rt_addr;
      rs_data_d   = wt_rs;
      rt_data_d   = wt_rt;
      imm_d       = bus.id_imm;
      use_imm_d   = bus.id_use_imm;
      rd_d        = bus.id_rd_addr;
      reg_write_d = bus.id_reg_write;
      mem_read_d  = bus.id_mem_read;
      mem_write_d = bus.id_mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_ctrl       = ctrl_q;
  assign bus.ex_op_a       = fwd_rs;
  assign bus.ex_op_b       = use_imm_q ? imm_q : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
  assign bus.ex_rd_addr    = rd_q;
  assign bus.ex_reg_write  = valid_q & reg_write_q;
  assign bus.ex_mem_read   = valid_q & mem_read_q;
  assign bus.ex_mem_write  = valid_q & mem_write_q;
  assign bus.stall_req     = stall_req;

endmodule
